// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
// vga_fb_arbiter: shares one single-port framebuffer RAM between per-line display prefetch (absolute priority) and CPU pixel writes.
// Latency: line_req edge -> first lb_wr_en 3 edges; accepted CPU write appears on mem_* at the next edge.
// Backpressure: cpu_wr_ready drops while a fetch owns the RAM; line_req is never stalled, and a request during a fetch sets err_overrun.
//
// Optional feature: define VGA_FB_CPU_STEAL_EN to give the CPU one RAM slot every STEAL_PERIOD fetch cycles.
//
// Ports:
//   vga_clk, sys_rst_n            clock, synchronous active-low reset
//   line_req, line_num            one-cycle prefetch request for a display line
//   fetch_busy, fetch_done        fetch in progress / one-cycle completion pulse
//   cpu_wr_valid/addr/data/ready  CPU pixel write handshake
//   mem_addr/re/we/wdata, mem_rdata   framebuffer RAM port (read data one cycle after mem_re)
//   lb_wr_en/addr/data            line-buffer write port
//   err_overrun, err_clr          sticky overrun flag and its clear
module vga_fb_arbiter #(
   parameter int H_DISP       = 640,
   parameter int V_DISP       = 480,
   parameter int AW           = 19,
   parameter int STEAL_PERIOD = 8
) (
   input  logic          vga_clk,
   input  logic          sys_rst_n,
   input  logic          line_req,
   input  logic [9:0]    line_num,
   output logic          fetch_busy,
   output logic          fetch_done,
   input  logic          cpu_wr_valid,
   input  logic [AW-1:0] cpu_wr_addr,
   input  logic [11:0]   cpu_wr_data,
   output logic          cpu_wr_ready,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [11:0]   mem_wdata,
   input  logic [11:0]   mem_rdata,
   output logic          lb_wr_en,
   output logic [9:0]    lb_wr_addr,
   output logic [11:0]   lb_wr_data,
   output logic          err_overrun,
   input  logic          err_clr
);

   localparam int XW = 10;
   localparam logic [XW-1:0] X_LAST      = XW'(H_DISP - 1);
   localparam logic [AW-1:0] LINE_STRIDE = AW'(H_DISP);
   localparam logic [31:0]   LINE_LIMIT  = 32'(V_DISP);
   localparam logic [31:0]   FB_WORDS    = 32'(H_DISP * V_DISP);

   // Elaboration-time sanity checks on the configuration.
   if (STEAL_PERIOD < 2 || STEAL_PERIOD > 255) begin : g_bad_steal_period
      $error("vga_fb_arbiter: STEAL_PERIOD must be within 2..255");
   end
   if (H_DISP < 1 || H_DISP > 1024 || (longint'(H_DISP) * V_DISP) > (longint'(1) << AW)) begin : g_bad_geometry
      $error("vga_fb_arbiter: H_DISP must fit 10 bits and H_DISP*V_DISP must fit AW bits");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [AW-1:0] base;        // first pixel address of the line being fetched
   logic [XW-1:0] x;           // next pixel index to read
   logic [XW-1:0] rd_idx;      // pixel index of the read currently on mem_re
   logic          pipe_vld;    // RAM is returning data for pipe_idx this cycle
   logic [XW-1:0] pipe_idx;

   logic line_ok, addr_ok;
   logic accept_req, issue_rd, drain_done, cpu_do_wr;
   logic steal_slot;

   assign line_ok = 32'(line_num) < LINE_LIMIT;
   assign addr_ok = 32'(cpu_wr_addr) < FB_WORDS;

`ifdef VGA_FB_CPU_STEAL_EN
   // Counts every FETCH cycle (issued or stolen) from 0; the last count of
   // each period is handed to the CPU instead of a read.
   localparam logic [7:0] STEAL_LAST = 8'(STEAL_PERIOD - 1);
   logic [7:0] steal_cnt;

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n || state != FETCH) begin
         steal_cnt <= '0;
      end else if (steal_cnt == STEAL_LAST) begin
         steal_cnt <= '0;
      end else begin
         steal_cnt <= steal_cnt + 8'd1;
      end
   end

   assign steal_slot = (state == FETCH) && (steal_cnt == STEAL_LAST);
`else
   assign steal_slot = 1'b0;
`endif

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      accept_req   = 1'b0;
      issue_rd     = 1'b0;
      drain_done   = 1'b0;
      // Ready is forced low during reset so no handshake completes that would be lost.
      cpu_wr_ready = sys_rst_n && (((state == IDLE) && !line_req) || steal_slot);
      cpu_do_wr    = 1'b0;

      case (state)
         IDLE: begin
            // Out-of-range lines are silently dropped.
            if (line_req && line_ok) begin
               accept_req = 1'b1;
               state_nxt  = FETCH;
            end
         end
         FETCH: begin
            if (!steal_slot) begin
               issue_rd = 1'b1;
               if (x == X_LAST) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Pipeline empty and the final line-buffer write is on the outputs.
            if (!mem_re && !pipe_vld && lb_wr_en) begin
               drain_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Out-of-range CPU addresses complete the handshake but never reach the RAM.
      cpu_do_wr = cpu_wr_valid && cpu_wr_ready && addr_ok;
   end

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         base        <= '0;
         x           <= '0;
         rd_idx      <= '0;
         pipe_vld    <= 1'b0;
         pipe_idx    <= '0;
         mem_addr    <= '0;
         mem_re      <= 1'b0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         lb_wr_en    <= 1'b0;
         lb_wr_addr  <= '0;
         lb_wr_data  <= '0;
         fetch_busy  <= 1'b0;
         fetch_done  <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (accept_req) begin
            base <= AW'(line_num) * LINE_STRIDE;
            x    <= '0;
         end

         // Read and write are mutually exclusive by construction: a CPU grant
         // only exists in IDLE or in a stolen slot, where no read is issued.
         mem_re <= issue_rd;
         mem_we <= cpu_do_wr;
         if (issue_rd) begin
            mem_addr <= base + AW'(x);
            rd_idx   <= x;
            x        <= x + 1'b1;
         end else if (cpu_do_wr) begin
            mem_addr  <= cpu_wr_addr;
            mem_wdata <= cpu_wr_data;
         end

         // Stage 1: RAM output valid; stage 2: registered into the line buffer.
         pipe_vld <= mem_re;
         pipe_idx <= rd_idx;
         lb_wr_en <= pipe_vld;
         if (pipe_vld) begin
            lb_wr_addr <= pipe_idx;
            lb_wr_data <= mem_rdata;
         end

         fetch_done <= drain_done;
         fetch_busy <= (state == FETCH) || ((state == DRAIN) && !drain_done);

         // A new overrun beats a simultaneous clear.
         if (line_req && state != IDLE) begin
            err_overrun <= 1'b1;
         end else if (err_clr) begin
            err_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

   localparam int H  = 640;
   localparam int V  = 480;
   localparam int AWB = 19;
   localparam int P  = 8;
`ifdef VGA_FB_CPU_STEAL_EN
   localparam bit STEAL = 1'b1;
`else
   localparam bit STEAL = 1'b0;
`endif

   logic           vga_clk = 1'b0;
   logic           sys_rst_n;
   logic           line_req;
   logic [9:0]     line_num;
   logic           fetch_busy, fetch_done;
   logic           cpu_wr_valid;
   logic [AWB-1:0] cpu_wr_addr;
   logic [11:0]    cpu_wr_data;
   logic           cpu_wr_ready;
   logic [AWB-1:0] mem_addr;
   logic           mem_re, mem_we;
   logic [11:0]    mem_wdata;
   logic [11:0]    mem_rdata = 12'h000;
   logic           lb_wr_en;
   logic [9:0]     lb_wr_addr;
   logic [11:0]    lb_wr_data;
   logic           err_overrun;
   logic           err_clr;

   vga_fb_arbiter #(.H_DISP(H), .V_DISP(V), .AW(AWB), .STEAL_PERIOD(P)) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
      .line_req(line_req), .line_num(line_num),
      .fetch_busy(fetch_busy), .fetch_done(fetch_done),
      .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr),
      .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
      .err_overrun(err_overrun), .err_clr(err_clr)
   );

   always #5 vga_clk = ~vga_clk;

   int cyc = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, cyc);
      end
   endtask

   // Framebuffer contents: a fixed function of the address.
   function automatic logic [11:0] ram_word(input logic [AWB-1:0] a);
      int v;
      v = int'(a);
      return 12'((v * 37) ^ (v >> 6) ^ 32'h5A5);
   endfunction

   // Synchronous-read RAM; garbage when not reading.
   always @(posedge vga_clk) begin
      if (mem_re) mem_rdata <= ram_word(mem_addr);
      else        mem_rdata <= 12'($urandom);
   end

   // ---------------- reference model: per-edge expectation tables ----------
   logic [AWB-1:0] exp_rd [int];   // edge -> read address
   logic [AWB-1:0] exp_wa [int];   // edge -> write address
   logic [11:0]    exp_wd [int];   // edge -> write data
   logic [9:0]     exp_lx [int];   // edge -> line-buffer index
   logic [AWB-1:0] exp_la [int];   // edge -> source RAM address
   bit             steal_cyc [int];
   bit             have_f = 1'b0;
   int             f_t0 = 0, f_done = 0;
   bit             err_cur = 1'b0;

   task automatic schedule_fetch(input int t0, input int ln);
      int base, j, xx, last;
      base = ln * H;
      j = 0; xx = 0; last = t0;
      while (xx < H) begin
         if (STEAL && (j % P) == P - 1) begin
            steal_cyc[t0 + j] = 1'b1;
         end else begin
            exp_rd[t0 + j + 1] = AWB'(base + xx);
            exp_lx[t0 + j + 3] = 10'(xx);
            exp_la[t0 + j + 3] = AWB'(base + xx);
            last = t0 + j + 1;
            xx++;
         end
         j++;
      end
      f_t0 = t0; f_done = last + 3; have_f = 1'b1;
   endtask

   always @(negedge vga_clk) begin : compare
      int n;
      bit idle, rdy, ex;
      n = cyc;
      idle = !have_f || (n >= f_done);
      rdy = sys_rst_n && ((idle && !line_req) || steal_cyc.exists(n) != 0);
      if (n >= 1) begin
         ex = exp_rd.exists(n) != 0;
         chk("mem_re", 32'(mem_re), 32'(ex));
         if (ex) chk("mem_addr_rd", 32'(mem_addr), 32'(exp_rd[n]));
         ex = exp_wa.exists(n) != 0;
         chk("mem_we", 32'(mem_we), 32'(ex));
         if (ex) begin
            chk("mem_addr_wr", 32'(mem_addr), 32'(exp_wa[n]));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd[n]));
         end
         ex = exp_lx.exists(n) != 0;
         chk("lb_wr_en", 32'(lb_wr_en), 32'(ex));
         if (ex) begin
            chk("lb_wr_addr", 32'(lb_wr_addr), 32'(exp_lx[n]));
            chk("lb_wr_data", 32'(lb_wr_data), 32'(ram_word(exp_la[n])));
         end
         chk("fetch_done", 32'(fetch_done), 32'(have_f && n == f_done));
         chk("fetch_busy", 32'(fetch_busy), 32'(have_f && n > f_t0 && n < f_done));
         chk("err_overrun", 32'(err_overrun), 32'(err_cur));
         chk("cpu_wr_ready", 32'(cpu_wr_ready), 32'(rdy));
      end
      exp_rd.delete(n); exp_wa.delete(n); exp_wd.delete(n);
      exp_lx.delete(n); exp_la.delete(n); steal_cyc.delete(n);
      // Apply this cycle's inputs to build expectations for later edges.
      if (!sys_rst_n) begin
         exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
         exp_lx.delete(); exp_la.delete(); steal_cyc.delete();
         have_f = 1'b0;
         err_cur = 1'b0;
      end else begin
         if (line_req && !idle) err_cur = 1'b1;
         else if (err_clr)      err_cur = 1'b0;
         if (cpu_wr_valid && rdy && int'(cpu_wr_addr) < H * V) begin
            exp_wa[n + 1] = cpu_wr_addr;
            exp_wd[n + 1] = cpu_wr_data;
         end
         if (line_req && idle && int'(line_num) < V) schedule_fetch(n + 1, int'(line_num));
      end
   end

   // ---------------- statistics for literal expectations -------------------
   int lb_cnt, done_cnt, rd_cnt, grant_busy, first_lb_edge, rd_last_edge;
   logic [AWB-1:0] rd_first, rd_last;
   logic [9:0] lb_last_addr;

   task automatic clr_stats();
      lb_cnt = 0; done_cnt = 0; rd_cnt = 0; grant_busy = 0;
      first_lb_edge = -1; rd_last_edge = -1;
      rd_first = '1; rd_last = '1; lb_last_addr = '1;
   endtask

   always @(negedge vga_clk) begin
      if (lb_wr_en) begin
         if (first_lb_edge < 0) first_lb_edge = cyc;
         lb_cnt++;
         lb_last_addr = lb_wr_addr;
      end
      if (fetch_done) done_cnt++;
      if (mem_re) begin
         if (rd_cnt == 0) rd_first = mem_addr;
         rd_last = mem_addr;
         rd_last_edge = cyc;
         rd_cnt++;
      end
      if (cpu_wr_valid && cpu_wr_ready && fetch_busy) grant_busy++;
   end

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
      repeat (3) step();
      chk("fetch_done_count", 32'(done_cnt), 32'd1);
   endtask

   int req_edge, snap;

   initial begin
      sys_rst_n = 1'b0; line_req = 1'b0; line_num = '0; err_clr = 1'b0;
      cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
      clr_stats();
      repeat (3) step();
      sys_rst_n = 1'b1;
      step();

      // Line 2 fetch with a CPU write pending throughout.
      clr_stats();
      cpu_wr_valid = 1'b1; cpu_wr_addr = 19'd1000; cpu_wr_data = 12'h123;
      line_req = 1'b1; line_num = 10'd2; req_edge = cyc + 1;
      step();
      line_req = 1'b0;
      wait_done();
      cpu_wr_valid = 1'b0;
      step();
      chk("t1_first_lb_edge", 32'(first_lb_edge), 32'(req_edge + 3));
      chk("t1_lb_count", 32'(lb_cnt), 32'd640);
      chk("t1_lb_last_addr", 32'(lb_last_addr), 32'd639);
      chk("t1_rd_first", 32'(rd_first), 32'd1280);
      chk("t1_rd_last", 32'(rd_last), 32'd1919);
      chk("t1_last_read_cycle", 32'(rd_last_edge - req_edge - 1), STEAL ? 32'd730 : 32'd639);
      chk("t1_cpu_grants_in_fetch", 32'(grant_busy), STEAL ? 32'd91 : 32'd0);

      // IDLE CPU writes: top pixel, then one past the framebuffer.
      cpu_wr_valid = 1'b1; cpu_wr_addr = 19'd307199; cpu_wr_data = 12'hF0A;
      @(negedge vga_clk); chk("t2_ready", 32'(cpu_wr_ready), 32'd1);
      step(); cpu_wr_valid = 1'b0;
      @(negedge vga_clk);
      chk("t2_mem_we", 32'(mem_we), 32'd1);
      chk("t2_mem_addr", 32'(mem_addr), 32'd307199);
      chk("t2_mem_wdata", 32'(mem_wdata), 32'hF0A);
      step();
      cpu_wr_valid = 1'b1; cpu_wr_addr = 19'd307200; cpu_wr_data = 12'h0F0;
      @(negedge vga_clk); chk("t2_ready_oob", 32'(cpu_wr_ready), 32'd1);
      step(); cpu_wr_valid = 1'b0;
      @(negedge vga_clk); chk("t2_mem_we_oob", 32'(mem_we), 32'd0);
      step();

      // line_req beats a simultaneous CPU write.
      clr_stats();
      line_req = 1'b1; line_num = 10'd0;
      cpu_wr_valid = 1'b1; cpu_wr_addr = 19'd50; cpu_wr_data = 12'h555;
      @(negedge vga_clk); chk("t3_ready_blocked", 32'(cpu_wr_ready), 32'd0);
      step(); line_req = 1'b0;
      for (int k = 0; k < 3000 && !fetch_done; k++) @(negedge vga_clk);
      chk("t3_done_seen", 32'(fetch_done), 32'd1);
      chk("t3_ready_first_idle", 32'(cpu_wr_ready), 32'd1);
      step(); cpu_wr_valid = 1'b0;
      @(negedge vga_clk);
      chk("t3_mem_we", 32'(mem_we), 32'd1);
      chk("t3_mem_addr", 32'(mem_addr), 32'd50);
      chk("t3_rd_first", 32'(rd_first), 32'd0);
      step();

      // Overrun handling.
      clr_stats();
      line_req = 1'b1; line_num = 10'd5;
      step(); line_req = 1'b0;
      repeat (100) step();
      line_req = 1'b1; step(); line_req = 1'b0;
      @(negedge vga_clk); chk("t4_overrun_set", 32'(err_overrun), 32'd1);
      repeat (20) step();
      line_req = 1'b1; err_clr = 1'b1; step(); line_req = 1'b0; err_clr = 1'b0;
      @(negedge vga_clk); chk("t4_set_beats_clear", 32'(err_overrun), 32'd1);
      wait_done();
      chk("t4_lb_count", 32'(lb_cnt), 32'd640);
      chk("t4_rd_first", 32'(rd_first), 32'd3200);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      @(negedge vga_clk); chk("t4_cleared", 32'(err_overrun), 32'd0);
      step();
      clr_stats();
      line_req = 1'b1; line_num = 10'd480; step(); line_req = 1'b0;
      repeat (5) step();
      chk("t4_oob_no_reads", 32'(rd_cnt), 32'd0);
      @(negedge vga_clk);
      chk("t4_oob_no_busy", 32'(fetch_busy), 32'd0);
      chk("t4_oob_no_error", 32'(err_overrun), 32'd0);
      step();

      // Reset in the middle of a fetch.
      clr_stats();
      line_req = 1'b1; line_num = 10'd7; step(); line_req = 1'b0;
      for (int k = 0; k < 3000 && rd_cnt < 300; k++) step();
      chk("t6_reached_300", 32'(rd_cnt >= 300), 32'd1);
      sys_rst_n = 1'b0; step(); sys_rst_n = 1'b1;
      @(negedge vga_clk);
      chk("t6_lb_after_rst", 32'(lb_wr_en), 32'd0);
      chk("t6_re_after_rst", 32'(mem_re), 32'd0);
      chk("t6_busy_after_rst", 32'(fetch_busy), 32'd0);
      snap = lb_cnt;
      repeat (10) step();
      chk("t6_no_more_lb", 32'(lb_cnt), 32'(snap));
      chk("t6_no_done", 32'(done_cnt), 32'd0);
      clr_stats();
      line_req = 1'b1; line_num = 10'd9; step(); line_req = 1'b0;
      wait_done();
      chk("t6_refetch_lb_count", 32'(lb_cnt), 32'd640);
      chk("t6_refetch_rd_first", 32'(rd_first), 32'd5760);

      // Randomized traffic against the model.
      for (int c = 0; c < 6000; c++) begin
         line_req     = ($urandom_range(0, 299) == 0);
         line_num     = 10'($urandom_range(0, 520));
         cpu_wr_valid = ($urandom_range(0, 1) == 1);
         cpu_wr_addr  = ($urandom_range(0, 15) == 0) ? 19'($urandom_range(307200, 524287))
                                                     : 19'($urandom_range(0, 307199));
         cpu_wr_data  = 12'($urandom);
         err_clr      = ($urandom_range(0, 40) == 0);
         sys_rst_n    = ($urandom_range(0, 2999) != 0);
         step();
      end
      line_req = 1'b0; cpu_wr_valid = 1'b0; err_clr = 1'b0; sys_rst_n = 1'b1;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (one pixel per word) between two users: per-line display prefetch and CPU pixel writes.
- On each line request, it bursts H_DISP pixels of the requested line into the external line buffer. The line buffer feeds the VGA timing generator's pixel_data.
- Display fetch has absolute priority. The CPU gets the RAM when the arbiter is idle, and optionally in stolen slots during a fetch.
- Sits between the VGA timing generator and the framebuffer RAM and CPU bus bridge.

Parameters:
- H_DISP, 640, pixels per line fetched per request.
- V_DISP, 480, valid line count; a line_num at or above this is out of range.
- AW, 19, framebuffer address width (H_DISP*V_DISP must be at most 2^AW).
- STEAL_PERIOD, 8, fetch-cycle period of CPU slot stealing (optional feature only); legal range 2..255.

Ports:
- vga_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  reset, synchronous, active-low.
- line_req  in  1  one-cycle pulse requesting a prefetch of line line_num.
- line_num  in  10  line index, sampled when line_req=1.
- fetch_busy  out  1  high from the first read issue to the last line-buffer write.
- fetch_done  out  1  one-cycle pulse on the cycle after the last line-buffer write.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_addr  in  AW  pixel address, equal to y*H_DISP+x.
- cpu_wr_data  in  12  RGB444 pixel.
- cpu_wr_ready  out  1  write accepted this cycle when valid&ready.
- mem_addr  out  AW  RAM address (registered).
- mem_re  out  1  RAM read strobe (registered); mem_rdata is valid on the following cycle.
- mem_we  out  1  RAM write strobe (registered).
- mem_wdata  out  12  RAM write data (registered).
- mem_rdata  in  12  RAM read data.
- lb_wr_en  out  1  line-buffer write (registered).
- lb_wr_addr  out  10  line-buffer index, 0..H_DISP-1.
- lb_wr_data  out  12  line-buffer data.
- err_overrun  out  1  sticky: a line_req arrived while not IDLE.
- err_clr  in  1  clears err_overrun.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including cpu_wr_ready and err_overrun.
  - The fetch index x, pipeline valids and steal counter go to 0.
  - Reset mid-fetch aborts the fetch with no further lb writes and no fetch_done.
- States:
  - IDLE:
    - line_req=1 with line_num<V_DISP latches base=line_num*H_DISP (AW-bit constant multiply), sets x=0 and moves to FETCH.
    - line_req=1 with line_num>=V_DISP is dropped: no fetch, no error.
  - FETCH:
    - Each read cycle issues mem_re=1, mem_addr=base+x on the next edge, then x++.
    - After the read with x=H_DISP-1 is issued, moves to DRAIN.
  - DRAIN:
    - Waits until the last lb write has been registered, then pulses fetch_done and returns to IDLE.
- Read pipeline:
  - Edge k: mem_re and mem_addr registered.
  - Cycle k+1: mem_rdata valid.
  - Edge k+2: lb_wr_en=1, lb_wr_data=mem_rdata, lb_wr_addr=x of that read.
  - Latency from the line_req edge to the first lb_wr_en is 3 edges.
  - Fetch without stealing: H_DISP read cycles plus 2 drain cycles.
- CPU arbitration:
  - cpu_wr_ready is combinational and equals (state==IDLE && !line_req), or a steal slot.
  - A line_req in the same cycle as cpu_wr_valid wins; the CPU write waits.
  - An accepted write registers mem_we=1, mem_addr=cpu_wr_addr, mem_wdata=cpu_wr_data on the next edge.
  - cpu_wr_addr >= H_DISP*V_DISP: the handshake completes but mem_we stays 0 (write dropped).
  - mem_we and mem_re are never both 1.
- Overrun:
  - line_req in FETCH or DRAIN is ignored and sets err_overrun; the current fetch continues unaffected.
  - err_clr clears err_overrun; set wins over a simultaneous clear.
- fetch_busy: 1 from the edge after line_req is accepted until the edge of fetch_done.

Optional Feature:
- Macro: VGA_FB_CPU_STEAL_EN.
- Defined:
  - A steal counter runs in FETCH, reset to 0 on FETCH entry, and wraps at STEAL_PERIOD-1.
  - On the cycle where count==STEAL_PERIOD-1, no read is issued, x holds, and cpu_wr_ready=1 (the write executes if valid).
  - DRAIN has no steal slots.
- Undefined:
  - cpu_wr_ready=0 throughout FETCH and DRAIN.
  - The counter logic is not synthesized.

Test Plan:
1. Reset, then line_req with line_num=2 -> reads at addresses 1280..1919 on consecutive cycles; lb_wr_addr runs 0..639 with data equal to RAM contents; first lb_wr_en on the 3rd edge after the request; fetch_done once; no CPU grant.
2. IDLE, cpu_wr_valid=1 addr=307199 data=12'hF0A -> ready=1; next edge mem_we=1, mem_addr=307199, mem_wdata=12'hF0A. Then addr=307200 -> ready=1 and mem_we stays 0.
3. line_req and cpu_wr_valid in the same cycle, line_num=0 -> ready=0; fetch starts at addr 0; CPU write accepted on the first IDLE cycle after fetch_done.
4. line_req during FETCH -> err_overrun=1 and the fetch completes normally. err_clr together with a new overrun line_req -> err_overrun stays 1; err_clr alone -> 0. line_num=480 in IDLE -> no fetch and no error.
5. VGA_FB_CPU_STEAL_EN, STEAL_PERIOD=8, cpu_wr_valid held high -> cpu_wr_ready high on FETCH cycles 7,15,...,727 (91 writes); the 640th read is issued on FETCH cycle 730.
6. sys_rst_n=0 at read 300 of a fetch -> all outputs 0 on the next edge; no lb writes and no fetch_done afterwards; a new line_req after reset fetches normally.
